// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS-style HI/LO multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Latency: mult/multu/div/divu occupy 33 cycles (32 ITER + 1 FIX); mthi/mtlo write HI/LO at the accepting edge.
// Backpressure: busy=1 while iterating; start is ignored (not queued) unless the unit is idle.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous reset, active low
//   start, op  - request and opcode (000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op)
//   a, b       - rs / rt operands
//   busy, done - iteration in progress / one-cycle pulse when HI/LO take an iterative result
//   hi, lo     - architectural HI and LO registers
//
// Build option: define MULT_DIV_DIVIDE_EN to include the divider; without it, 010/011 are no-ops.

module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [4:0]  cnt;
  logic        res_neg;   // product / quotient must be negated in FIX
  logic [31:0] b_mag;     // |b|: multiplicand for multiply, divisor for divide
  logic [31:0] acc_hi;    // product high half / partial remainder
  logic [31:0] acc_lo;    // multiplier being consumed / dividend shifting into quotient

  // Request decode
  logic op_is_mul, op_is_div, signed_op, accept_iter;
  logic [31:0] abs_a, abs_b;

  assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULT_DIV_DIVIDE_EN
  assign op_is_div = (op == 3'b010) || (op == 3'b011);
`else
  assign op_is_div = 1'b0;
`endif
  // Only the even opcodes among the iterative ops (mult, div) are signed.
  assign signed_op   = ~op[0];
  assign accept_iter = (state == IDLE) && start && (op_is_mul || op_is_div);
  assign abs_a       = (signed_op && a[31]) ? (~a + 32'd1) : a;
  assign abs_b       = (signed_op && b[31]) ? (~b + 32'd1) : b;

  // Multiply step: add multiplicand if the current multiplier bit is set,
  // then shift the 64-bit {acc_hi, acc_lo} right by one, carry included.
  logic [32:0] mul_sum;
  logic [31:0] mul_hi_nxt, mul_lo_nxt;
  assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : 33'd0);
  assign mul_hi_nxt = mul_sum[32:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo[31:1]};

  // Sign fix for the product: magnitudes were multiplied.
  logic [63:0] prod_mag, prod_fix;
  assign prod_mag = {acc_hi, acc_lo};
  assign prod_fix = res_neg ? (~prod_mag + 64'd1) : prod_mag;

  logic [31:0] res_hi, res_lo;

`ifdef MULT_DIV_DIVIDE_EN
  logic        is_div;
  logic        rem_neg;   // remainder takes the dividend's sign
  logic [31:0] a_raw;     // raw dividend, returned as HI on divide by zero

  // Restoring divide step. The partial remainder is always below the divisor,
  // so the 33-bit trial difference's top bit is a reliable borrow flag.
  logic [32:0] div_shift, div_trial;
  logic [31:0] div_hi_nxt, div_lo_nxt;
  assign div_shift  = {acc_hi, acc_lo[31]};
  assign div_trial  = div_shift - {1'b0, b_mag};
  assign div_hi_nxt = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
  assign div_lo_nxt = {acc_lo[30:0], ~div_trial[32]};

  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (is_div) begin
      if (b_mag == 32'd0) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_neg ? (~acc_hi + 32'd1) : acc_hi;
        res_lo = res_neg ? (~acc_lo + 32'd1) : acc_lo;
      end
    end
  end
`else
  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and busy
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept_iter) state_nxt = ITER;
      end
      ITER:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 5'd0;
      res_neg <= 1'b0;
      b_mag   <= 32'd0;
      acc_hi  <= 32'd0;
      acc_lo  <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      done    <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
      is_div  <= 1'b0;
      rem_neg <= 1'b0;
      a_raw   <= 32'd0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && op == OP_MTHI) hi <= a;
          if (start && op == OP_MTLO) lo <= a;
          if (accept_iter) begin
            cnt     <= 5'd0;
            res_neg <= signed_op && (a[31] ^ b[31]);
            b_mag   <= abs_b;
            acc_hi  <= 32'd0;
            acc_lo  <= abs_a;
`ifdef MULT_DIV_DIVIDE_EN
            is_div  <= op_is_div;
            rem_neg <= signed_op && a[31];
            a_raw   <= a;
`endif
          end
        end
        ITER: begin
          cnt <= cnt + 5'd1;
`ifdef MULT_DIV_DIVIDE_EN
          if (is_div) begin
            acc_hi <= div_hi_nxt;
            acc_lo <= div_lo_nxt;
          end else
`endif
          begin
            acc_hi <= mul_hi_nxt;
            acc_lo <= mul_lo_nxt;
          end
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit against an arithmetic reference model.
// Latency: expects 33 busy cycles per iterative op, done on the edge that ends busy.
// Backpressure: pokes start during busy and expects it to be ignored.

module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

`ifdef MULT_DIV_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference model: MIPS HI/LO semantics in plain 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output bit iter, output logic [31:0] nh, output logic [31:0] nl);
    longint     sa, sb, sp, sq, sr;
    logic [63:0] up;
    iter = 1'b0;
    nh   = exp_hi;
    nl   = exp_lo;
    sa   = longint'($signed(av));
    sb   = longint'($signed(bv));
    case (o)
      3'd0: begin
        iter = 1'b1;
        sp   = sa * sb;
        nh   = sp[63:32];
        nl   = sp[31:0];
      end
      3'd1: begin
        iter = 1'b1;
        up   = 64'(av) * 64'(bv);
        nh   = up[63:32];
        nl   = up[31:0];
      end
      3'd2: if (DIV_EN) begin
        iter = 1'b1;
        if (bv == 32'd0) begin
          nh = av; nl = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          nh = sr[31:0];
          nl = sq[31:0];
        end
      end
      3'd3: if (DIV_EN) begin
        iter = 1'b1;
        if (bv == 32'd0) begin
          nh = av; nl = 32'hFFFF_FFFF;
        end else begin
          nh = av % bv;
          nl = av / bv;
        end
      end
      3'd4: nh = av;
      3'd5: nl = av;
      default: ;
    endcase
  endtask

  // Issue one request; optionally pulse start again mid-operation (must be ignored).
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input bit poke);
    bit          iter, held;
    logic [31:0] nh, nl;
    int          bc, dc;
    model(o, av, bv, iter, nh, nl);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    if (!iter) begin
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== nh || lo !== nl) begin
        n_err++;
        $display("FAIL immediate op%0d: busy=%b done=%b hi=%h lo=%h, want busy=0 done=0 hi=%h lo=%h",
                 o, busy, done, hi, lo, nh, nl);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL immediate_quiet op%0d: busy=%b done=%b, want 0 0", o, busy, done);
      end
    end else begin
      bc = 0; dc = 0; held = 1'b1;
      while (busy === 1'b1 && bc < 60) begin
        bc++;
        if (done !== 1'b0) dc++;
        if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
        if (poke && bc == 5) begin
          start = 1'b1; op = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      n_cmp++;
      if (bc != 33) begin
        n_err++;
        $display("FAIL busy_len op%0d: got %0d cycles, want 33", o, bc);
      end
      n_cmp++;
      if (!held || dc != 0) begin
        n_err++;
        $display("FAIL hold_during_busy op%0d: hi/lo held=%b early done cycles=%0d, want held=1 done=0", o, held, dc);
      end
      n_cmp++;
      if (done !== 1'b1 || hi !== nh || lo !== nl) begin
        n_err++;
        $display("FAIL result op%0d a=%h b=%h: done=%b hi=%h lo=%h, want done=1 hi=%h lo=%h",
                 o, av, bv, done, hi, lo, nh, nl);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL done_pulse op%0d: done=%b busy=%b a cycle later, want 0 0", o, done, busy);
      end
    end
    exp_hi = nh;
    exp_lo = nl;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end
    start = 1'b0;
    reset = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  task automatic test_multiply();
    run_op(3'd1, 32'hFEDC_1234, 32'hFFFF_ABCD, 1'b0);
    n_cmp++;
    if (hi !== 32'hFEDB_BE61 || lo !== 32'h042F_4FA4) begin
      n_err++;
      $display("FAIL multu_vector: hi=%h lo=%h, want FEDBBE61 042F4FA4", hi, lo);
    end
    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_err++;
      $display("FAIL mult_vector: hi=%h lo=%h, want FFFFFFFF FFFFFFFA", hi, lo);
    end
  endtask

  task automatic test_divide();
    // In a build without the divider these run as no-ops through the model.
    run_op(3'd3, 32'd100, 32'd7, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd3, 32'h1234_5678, 32'h0000_0000, 1'b0);
`ifdef MULT_DIV_DIVIDE_EN
    n_cmp++;
    if (hi !== 32'h1234_5678 || lo !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL divu_by_zero: hi=%h lo=%h, want 12345678 FFFFFFFF", hi, lo);
    end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    n_cmp++;
    if (hi !== 32'h0000_0000 || lo !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL div_overflow: hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end
`endif
  endtask

  task automatic test_move();
    run_op(3'd4, 32'hAAAA_5555, 32'h0, 1'b0);
    run_op(3'd5, 32'h5555_AAAA, 32'h0, 1'b0);
    n_cmp++;
    if (hi !== 32'hAAAA_5555 || lo !== 32'h5555_AAAA) begin
      n_err++;
      $display("FAIL move_vector: hi=%h lo=%h, want AAAA5555 5555AAAA", hi, lo);
    end
  endtask

  task automatic test_busy_ignore();
    run_op(3'd1, $urandom, $urandom, 1'b1);
    run_op(3'd0, $urandom, $urandom, 1'b1);
  endtask

  task automatic test_reserved();
    run_op(3'd6, $urandom, $urandom, 1'b0);
    run_op(3'd7, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    op = 3'd1; a = 32'hFEDC_1234; b = 32'hFFFF_ABCD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL reset_no_resume: activity after aborted op, busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    end
    // Release happened 1 ns after an edge: the next request lands on the first edge.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_op(3'd0, 32'h0000_1234, 32'hFFFF_0010, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(3'd4, 32'h0102_0304, 32'h0, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'd5, 32'h0A0B_0C0D, 32'h0, 1'b0);
    run_op(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    test_reset();
    test_multiply();
    test_divide();
    test_move();
    test_busy_ignore();
    test_reserved();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous reset, active-low.
REQ-003 The block SHALL have port start, input, 1 bit: request a new operation; sampled on a rising clk edge while busy=0.
REQ-004 The block SHALL have port op, input, 3 bits: operation code, 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved (no-op).
REQ-005 The block SHALL have port a, input, 32 bits: rs operand, multiplicand or dividend, or mthi/mtlo source.
REQ-006 The block SHALL have port b, input, 32 bits: rt operand, multiplier or divisor.
REQ-007 The block SHALL have port busy, output, 1 bit: iterative operation in progress; the CPU stalls mfhi/mflo and new mult/div while busy=1.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO take an iterative result.
REQ-009 The block SHALL have port hi, output, 32 bits: HI register.
REQ-010 The block SHALL have port lo, output, 32 bits: LO register.

Function
REQ-011 The block SHALL implement states IDLE, ITER, FIX; IDLE->ITER on accepted mult/multu/div/divu; ITER->FIX after 32 iterations; FIX->IDLE after 1 cycle.
REQ-012 The block SHALL accept start only in IDLE; start while busy=1 SHALL be ignored with no queueing.
REQ-013 On acceptance (edge E0) the block SHALL latch a, b and op; busy=1 from E0 through E33 (32 ITER cycles + 1 FIX cycle).
REQ-014 At edge E33 the block SHALL update hi/lo, drop busy to 0, and assert done=1 for exactly one cycle.
REQ-015 hi/lo SHALL hold their previous values throughout busy, never showing partial results.
REQ-016 mult/multu SHALL form the 64-bit product by radix-2 shift-add, one bit per ITER cycle; HI=product[63:32], LO=product[31:0].
REQ-017 Signed ops SHALL compute on magnitudes in ITER, and FIX SHALL apply sign: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-018 div/divu SHALL use restoring division, one quotient bit per ITER cycle; LO=quotient (truncated toward zero), HI=remainder.
REQ-019 On divide by zero the block SHALL use the full latency with LO=0xFFFFFFFF and HI=a.
REQ-020 For div 0x80000000 / 0xFFFFFFFF the block SHALL yield LO=0x80000000 and HI=0x00000000.
REQ-021 mthi/mtlo SHALL write a to hi/lo at the accepting edge; busy SHALL stay 0 and done SHALL stay 0.
REQ-022 Reserved op codes SHALL have no effect on hi/lo, busy or done.

Reset
REQ-023 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, hi=0, lo=0, and clear internal operand/counter state.
REQ-024 Reset asserted mid-operation SHALL abort the operation, with no done pulse and no HI/LO update after release.
REQ-025 After reset release the block SHALL accept start on the first rising edge.

Configuration
REQ-026 With MULT_DIV_DIVIDE_EN defined, the block SHALL implement div/divu per REQ-018..REQ-020.
REQ-027 With MULT_DIV_DIVIDE_EN undefined, the block SHALL omit the divider datapath and treat op 010/011 as reserved no-ops (busy=0, done=0, hi/lo unchanged); multiply and mthi/mtlo SHALL behave identically to the defined build.

Verification
REQ-028 multu, a=0xFEDC1234, b=0xFFFFABCD -> busy high 33 cycles, done pulse, HI=0xFEDBBE61, LO=0x042F4FA4 (HI+LO=0x030B0E05).
REQ-029 mult, a=0xFFFFFFFE, b=0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; divu, a=100, b=7 -> LO=0x0000000E, HI=0x00000002.
REQ-030 div, a=0xFFFFFFF9, b=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div, a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 divu, a=0x12345678, b=0 -> 33 busy cycles, LO=0xFFFFFFFF, HI=0x12345678.
REQ-032 mthi a=0xAAAA5555 then mtlo a=0x5555AAAA -> hi/lo updated at each accepting edge, busy and done never high; second start during a multu busy ignored.
REQ-033 reset=0 at cycle 10 of a multu -> hi=lo=0, busy=0, no done; new mult after release completes normally.
